// File: rtl/iq_pkg.sv
// rtl/iq_pkg.sv - instruction entry layout, widths and pack/unpack helpers
package iq_pkg;

    localparam int MAJ_OP_W = 4;
    localparam int REG_W    = 5;
    localparam int SCALE_W  = 2;
    localparam int MIN_OP_W = 4;
    localparam int ADDR_W   = 48;
    localparam int SUB_W    = 1;

    localparam int ENTRY_W = MAJ_OP_W + 3 * REG_W + SCALE_W + MIN_OP_W + 1 + ADDR_W + SUB_W;

    typedef struct packed {
        logic [MAJ_OP_W-1:0] maj_op;
        logic [REG_W-1:0]    src1;
        logic [REG_W-1:0]    src2;
        logic [SCALE_W-1:0]  off_scale;
        logic [REG_W-1:0]    dest;
        logic [MIN_OP_W-1:0] min_op;
        logic                has_addr;
        logic [ADDR_W-1:0]   addr;
        logic [SUB_W-1:0]    off_sub;
    } instr_entry_t;

    function automatic logic [ENTRY_W-1:0] pack(input instr_entry_t e);
        return e;
    endfunction

    function automatic instr_entry_t unpack(input logic [ENTRY_W-1:0] v);
        return instr_entry_t'(v);
    endfunction

endpackage

// File: rtl/iq_ptr_ctrl.sv
// rtl/iq_ptr_ctrl.sv - read/write pointers, occupancy and registered almost_full
module iq_ptr_ctrl #(
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 1,
    parameter int PTR_W     = $clog2(DEPTH),
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [CNT_W-1:0] count,
    output logic             almost_full
);

    localparam logic [CNT_W-1:0] AF_TH = CNT_W'(DEPTH - AF_MARGIN);

    logic [CNT_W-1:0] next_count;

    always_comb begin
        next_count = count;
        if (flush)
            next_count = '0;
        else if (push && !pop)
            next_count = count + CNT_W'(1);
        else if (pop && !push)
            next_count = count - CNT_W'(1);
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count       <= next_count;
            almost_full <= (next_count >= AF_TH);
        end
    end

endmodule

// File: rtl/instr_queue_param.sv
// rtl/instr_queue_param.sv - parametrised FWFT instruction queue; INSTR_QUEUE_BYPASS_EN enables empty pass-through
module instr_queue_param #(
    parameter int DEPTH     = 8,
    parameter int ENTRY_W   = iq_pkg::ENTRY_W,
    parameter int AF_MARGIN = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [ENTRY_W-1:0]           enq_data,
    output logic                         deq_valid,
    input  logic                         deq_ready,
    output logic [ENTRY_W-1:0]           deq_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               empty;
    logic               bypass_take;
    logic               push;
    logic               pop;

    assign empty     = (count == '0);
    assign enq_ready = (count != CNT_W'(DEPTH)) && !flush;

`ifdef INSTR_QUEUE_BYPASS_EN
    // An entry consumed straight through never touches storage or the pointers.
    assign bypass_take = empty && enq_valid && !flush && deq_ready;
    assign deq_valid   = !empty || (enq_valid && !flush);
    assign deq_data    = empty ? enq_data : mem[rd_ptr];
`else
    assign bypass_take = 1'b0;
    assign deq_valid   = !empty;
    assign deq_data    = mem[rd_ptr];
`endif

    assign push = enq_valid && enq_ready && !bypass_take;
    assign pop  = !empty && deq_ready && !flush;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= enq_data;
    end

    iq_ptr_ctrl #(
        .DEPTH     (DEPTH),
        .AF_MARGIN (AF_MARGIN),
        .PTR_W     (PTR_W),
        .CNT_W     (CNT_W)
    ) u_ptr_ctrl (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .push        (push),
        .pop         (pop),
        .rd_ptr      (rd_ptr),
        .wr_ptr      (wr_ptr),
        .count       (count),
        .almost_full (almost_full)
    );

`ifndef SYNTHESIS
    // Fetch must hold a stalled entry steady; a flush redirect may replace it.
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (enq_valid && !enq_ready && !flush) |=> (!enq_valid || flush || $stable(enq_data)));
`endif

endmodule

// File: tb/tb_instr_queue_param.sv
// tb/tb_instr_queue_param.sv - queue-model bench for instr_queue_param
module tb_instr_queue_param;
    import iq_pkg::*;

    localparam int DEPTH     = 8;
    localparam int AF_MARGIN = 1;
    localparam int W         = ENTRY_W;
    localparam int CW        = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          enq_valid;
    logic          enq_ready;
    logic [W-1:0]  enq_data;
    logic          deq_valid;
    logic          deq_ready;
    logic [W-1:0]  deq_data;
    logic [CW-1:0] count;
    logic          almost_full;

    instr_queue_param #(.DEPTH(DEPTH), .ENTRY_W(W), .AF_MARGIN(AF_MARGIN)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .enq_valid   (enq_valid),
        .enq_ready   (enq_ready),
        .enq_data    (enq_data),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
        .deq_data    (deq_data),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] mq[$];
    logic [W-1:0] popped[$];
    bit           m_af;

    task automatic chk_i(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_d(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [W-1:0] mk(input logic [7:0] v);
        instr_entry_t e;
        e.maj_op    = v[3:0];
        e.src1      = v[4:0];
        e.src2      = ~v[4:0];
        e.off_scale = v[1:0];
        e.dest      = v[7:3];
        e.min_op    = ~v[3:0];
        e.has_addr  = v[0];
        e.addr      = {6{v}};
        e.off_sub   = v[7];
        return pack(e);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_af = 1'b0;
    endtask

    // One cycle: drive, compare DUT against the queue model, clock, update model.
    task automatic step(input bit ev, input logic [W-1:0] ed, input bit dr, input bit fl);
        bit e_rdy;
        bit e_vld;
        bit byp;
        @(negedge clk);
        enq_valid = ev;
        enq_data  = ed;
        deq_ready = dr;
        flush     = fl;
        #1;
        e_rdy = (mq.size() < DEPTH) && !fl;
        byp   = 1'b0;
`ifdef INSTR_QUEUE_BYPASS_EN
        byp   = (mq.size() == 0) && ev && !fl;
`endif
        e_vld = (mq.size() > 0) || byp;
        chk_i("count", int'(count), mq.size());
        chk_i("enq_ready", int'(enq_ready), int'(e_rdy));
        chk_i("deq_valid", int'(deq_valid), int'(e_vld));
        chk_i("almost_full", int'(almost_full), int'(m_af));
        if (e_vld) chk_d("deq_data", deq_data, byp ? ed : mq[0]);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else if (byp && dr) begin
            popped.push_back(ed);
        end else begin
            if (mq.size() > 0 && dr) popped.push_back(mq.pop_front());
            if (ev && e_rdy) mq.push_back(ed);
        end
        m_af = (mq.size() >= DEPTH - AF_MARGIN);
    endtask

    task automatic idle_inputs();
        enq_valid = 1'b0;
        enq_data  = '0;
        deq_ready = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_i("reset_count", int'(count), 0);
        chk_i("reset_deq_valid", int'(deq_valid), 0);
        chk_i("reset_enq_ready", int'(enq_ready), 1);
        chk_i("reset_af", int'(almost_full), 0);
        step(0, '0, 0, 0);

        // Fill with dispatch stalled.
        for (int i = 1; i <= 8; i++) begin
            step(1, mk(8'(i)), 0, 0);
            #1;
            if (i == 6) chk_i("af_after_6", int'(almost_full), 0);
            if (i == 7) chk_i("af_after_7", int'(almost_full), 1);
        end
        chk_i("full_count", int'(count), 8);
        chk_i("full_enq_ready", int'(enq_ready), 0);
        step(1, mk(8'hEE), 0, 0);
        #1;
        chk_i("reject_9th_count", int'(count), 8);

        // Pop 3, refill across the wrap, drain all.
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
        chk_i("pop3_len", popped.size(), 3);
        for (int i = 0; i < 3; i++)
            chk_d("pop3_data", (popped.size() > i) ? popped[i] : 'x, mk(8'(i + 1)));
        popped.delete();
        for (int i = 9; i <= 11; i++) step(1, mk(8'(i)), 0, 0);
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
        #1;
        chk_i("drain_len", popped.size(), 8);
        for (int i = 0; i < 8; i++)
            chk_d("drain_data", (popped.size() > i) ? popped[i] : 'x, mk(8'(i + 4)));
        chk_i("drain_count", int'(count), 0);
        chk_i("drain_af", int'(almost_full), 0);

        // Steady push+pop at occupancy 4.
        popped.delete();
        for (int i = 0; i < 4; i++) step(1, mk(8'(8'h10 + i)), 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, mk(8'(8'h14 + i)), 1, 0);
            #1;
            chk_i("pushpop_count", int'(count), 4);
        end
        for (int i = 0; i < 10; i++)
            chk_d("pushpop_order", (popped.size() > i) ? popped[i] : 'x, mk(8'(8'h10 + i)));

        // Flush at occupancy 5 with both handshakes active.
        step(1, mk(8'h1E), 0, 0);
        popped.delete();
        step(1, mk(8'h55), 1, 1);
        #1;
        chk_i("flush_count", int'(count), 0);
        chk_i("flush_deq_valid", int'(deq_valid), 0);
        chk_i("flush_no_pop", popped.size(), 0);
        step(0, '0, 1, 0);

        // Empty push with dispatch stalled: visible next cycle.
        step(1, mk(8'h66), 0, 0);
        #1;
        chk_i("empty_push_valid", int'(deq_valid), 1);
        chk_d("empty_push_data", deq_data, mk(8'h66));
        chk_i("empty_push_count", int'(count), 1);
        step(0, '0, 1, 0);

`ifdef INSTR_QUEUE_BYPASS_EN
        popped.delete();
        @(negedge clk);
        enq_valid = 1'b1;
        enq_data  = mk(8'h77);
        deq_ready = 1'b1;
        #1;
        chk_i("bypass_valid", int'(deq_valid), 1);
        chk_d("bypass_data", deq_data, mk(8'h77));
        step(1, mk(8'h77), 1, 0);
        #1;
        chk_i("bypass_count", int'(count), 0);
        chk_i("bypass_consumed", popped.size(), 1);
`endif

        // Asynchronous reset mid-operation.
        step(1, mk(8'h21), 0, 0);
        step(1, mk(8'h22), 0, 0);
        @(negedge clk);
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        chk_i("async_rst_count", int'(count), 0);
        chk_i("async_rst_deq_valid", int'(deq_valid), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(0, '0, 1, 0);
        step(1, mk(8'h33), 1, 0);
        step(0, '0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
